// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encoding, FSM states and lane helpers.
// The misaligned-access trap is enabled by defining LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } lsu_state_e;

    // Clears the low address bits a half or word access cannot use.
    function automatic logic [1:0] align_lane(input lsu_size_e size, input logic [1:0] lane);
        logic [1:0] res;
        case (size)
            SZ_HALF: res = {lane[1], 1'b0};
            SZ_WORD: res = 2'b00;
            default: res = lane;
        endcase
        return res;
    endfunction

    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] lane);
        logic res;
        case (size)
            SZ_HALF: res = lane[0];
            SZ_WORD: res = |lane;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends load data, and merges store
// data into a previously read memory word.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATAW = 32
) (
    input  logic [DATAW-1:0] rd_word_i,
    input  logic [DATAW-1:0] st_data_i,
    input  logic [1:0]       lane_i,
    input  lsu_size_e        size_i,
    input  logic             signed_i,
    output logic [DATAW-1:0] ld_data_o,
    output logic [DATAW-1:0] st_word_o
);

    logic [4:0]       shift_s;
    logic [DATAW-1:0] shifted_s;
    logic [DATAW-1:0] mask_s;

    // Load extraction/extension and store lane merge from the selected lane.
    always_comb begin
        shift_s   = {lane_i, 3'b000};
        shifted_s = rd_word_i >> shift_s;
        ld_data_o = {DATAW{1'b0}};
        mask_s    = {DATAW{1'b0}};
        case (size_i)
            SZ_BYTE: begin
                ld_data_o = {{(DATAW-8){signed_i & shifted_s[7]}}, shifted_s[7:0]};
                mask_s    = {{(DATAW-8){1'b0}}, 8'hFF};
            end
            SZ_HALF: begin
                ld_data_o = {{(DATAW-16){signed_i & shifted_s[15]}}, shifted_s[15:0]};
                mask_s    = {{(DATAW-16){1'b0}}, 16'hFFFF};
            end
            SZ_WORD: begin
                ld_data_o = rd_word_i;
                mask_s    = {DATAW{1'b1}};
            end
            default: begin
                ld_data_o = {DATAW{1'b0}};
                mask_s    = {DATAW{1'b0}};
            end
        endcase
        st_word_o = (rd_word_i & ~(mask_s << shift_s)) | ((st_data_i & mask_s) << shift_s);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, read-modify-write for sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATAW = 32,
    parameter int MEM   = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [DATAW-1:0] req_addr,
    input  logic [DATAW-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [DATAW-1:0] resp_rdata,
    output logic             resp_err,
    output logic [DATAW-1:0] mem_address,
    output logic [DATAW-1:0] mem_writeData,
    output logic             mem_writeEn,
    input  logic [DATAW-1:0] mem_RD
);

    localparam logic [DATAW-1:0] MEM_LIMIT = DATAW'(MEM);

    lsu_state_e       state_q, state_d;
    logic             we_q, we_d;
    lsu_size_e        size_q, size_d;
    logic             signed_q, signed_d;
    logic [1:0]       lane_q, lane_d;
    logic [DATAW-1:0] wdata_q, wdata_d;
    logic [DATAW-1:0] mem_address_q, mem_address_d;
    logic [DATAW-1:0] mem_wdata_q, mem_wdata_d;
    logic             mem_we_q, mem_we_d;
    logic             resp_valid_q, resp_valid_d;
    logic [DATAW-1:0] resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;

    lsu_size_e        req_size_s;
    logic [DATAW-1:0] word_idx_s;
    logic [1:0]       req_lane_s;
    logic             misalign_s;
    logic             req_err_s;
    logic [DATAW-1:0] ld_data_s;
    logic [DATAW-1:0] st_word_s;

    assign req_size_s = lsu_size_e'(req_size);
    assign word_idx_s = {2'b00, req_addr[DATAW-1:2]};

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_s = is_misaligned(req_size_s, req_addr[1:0]);
    assign req_lane_s = req_addr[1:0];
`else
    assign misalign_s = 1'b0;
    assign req_lane_s = align_lane(req_size_s, req_addr[1:0]);
`endif

    assign req_err_s = (req_size_s == SZ_ILL) || (word_idx_s >= MEM_LIMIT) || misalign_s;

    lsu_lane_align #(.DATAW(DATAW)) u_align (
        .rd_word_i (mem_RD),
        .st_data_i (wdata_q),
        .lane_i    (lane_q),
        .size_i    (size_q),
        .signed_i  (signed_q),
        .ld_data_o (ld_data_s),
        .st_word_o (st_word_s)
    );

    // Next-state and output-register logic of the request FSM.
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        size_d        = size_q;
        signed_d      = signed_q;
        lane_d        = lane_q;
        wdata_d       = wdata_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_we_d      = 1'b0;
        resp_valid_d  = resp_valid_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size_s;
                    signed_d = req_signed;
                    lane_d   = req_lane_s;
                    wdata_d  = req_wdata;
                    if (req_err_s) begin
                        // Errors bypass memory entirely; mem_address keeps its old value.
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = {DATAW{1'b0}};
                    end else if (req_we && (req_size_s == SZ_WORD)) begin
                        state_d       = ST_WRITE;
                        mem_address_d = word_idx_s;
                        mem_we_d      = 1'b1;
                        mem_wdata_d   = req_wdata;
                    end else begin
                        state_d       = ST_READ;
                        mem_address_d = word_idx_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (we_q) begin
                    state_d     = ST_WRITE;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = st_word_s;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = ld_data_s;
                end
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = {DATAW{1'b0}};
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            we_q          <= 1'b0;
            size_q        <= SZ_BYTE;
            signed_q      <= 1'b0;
            lane_q        <= 2'b00;
            wdata_q       <= {DATAW{1'b0}};
            mem_address_q <= {DATAW{1'b0}};
            mem_wdata_q   <= {DATAW{1'b0}};
            mem_we_q      <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= {DATAW{1'b0}};
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            size_q        <= size_d;
            signed_q      <= signed_d;
            lane_q        <= lane_d;
            wdata_q       <= wdata_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_we_q      <= mem_we_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign mem_address   = mem_address_q;
    assign mem_writeData = mem_wdata_q;
    assign mem_writeEn   = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of transactions against a word memory
// model, scoreboard queue of expected responses, plus backpressure and mid-write reset sequences.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic        mem_writeEn;
    logic [31:0] mem_RD;

    logic [31:0] mem [0:63];
    int          wr_cnt;
    logic [31:0] wr_addr_last;
    logic [31:0] wr_data_last;

    int errors;
    int checks;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_nw;
        logic [31:0] exp_waddr;
        logic [31:0] exp_wword;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    load_store_unit #(.DATAW(32), .MEM(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_writeEn   (mem_writeEn),
        .mem_RD        (mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_RD = (mem_address < 32'd64) ? mem[mem_address[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_writeEn) begin
            mem[mem_address[5:0]] <= mem_writeData;
            wr_cnt       <= wr_cnt + 1;
            wr_addr_last <= mem_address;
            wr_data_last <= mem_writeData;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"},  32'(req_ready),   32'h1);
        check({tag, "_resp_valid"}, 32'(resp_valid),  32'h0);
        check({tag, "_resp_err"},   32'(resp_err),    32'h0);
        check({tag, "_resp_rdata"}, resp_rdata,       32'h0);
        check({tag, "_mem_we"},     32'(mem_writeEn), 32'h0);
        check({tag, "_mem_addr"},   mem_address,      32'h0);
        check({tag, "_mem_wdata"},  mem_writeData,    32'h0);
    endtask

    task automatic run_txn(input vec_t v, input int hold);
        int   lat;
        int   wr0;
        exp_t e;
        @(negedge clk);
        check({v.name, "_req_ready"}, 32'(req_ready), 32'h1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        wr0        = wr_cnt;
        @(posedge clk);
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.lat   = v.exp_lat;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check({v.name, "_latency"}, 32'(lat), 32'(e.lat));
        check({v.name, "_rdata"},   resp_rdata, e.rdata);
        check({v.name, "_err"},     32'(resp_err), 32'(e.err));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({v.name, "_hold_valid"}, 32'(resp_valid), 32'h1);
            check({v.name, "_hold_rdata"}, resp_rdata, e.rdata);
            check({v.name, "_hold_err"},   32'(resp_err), 32'(e.err));
            check({v.name, "_hold_ready"}, 32'(req_ready), 32'h0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({v.name, "_valid_drop"}, 32'(resp_valid), 32'h0);
        check({v.name, "_writes"}, 32'(wr_cnt - wr0), 32'(v.exp_nw));
        if (v.exp_nw > 0) begin
            check({v.name, "_waddr"}, wr_addr_last, v.exp_waddr);
            check({v.name, "_wword"}, wr_data_last, v.exp_wword);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        errors = 0;
        checks = 0;
        wr_cnt = 0;
        wr_addr_last = 32'h0;
        wr_data_last = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;

        // name, we, size, sgn, addr, wdata, rdata, err, lat, nwrites, waddr, wword
        vecs.push_back('{"sw_beef",   1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'd4, 32'hDEADBEEF});
        vecs.push_back('{"lw_beef",   1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'd0, 32'h0});
        vecs.push_back('{"sw_1122",   1'b1, 2'b10, 1'b0, 32'h10,  32'h11223344, 32'h0,        1'b0, 2, 1, 32'd4, 32'h11223344});
        vecs.push_back('{"sb_aa",     1'b1, 2'b00, 1'b0, 32'h11,  32'h000000AA, 32'h0,        1'b0, 3, 1, 32'd4, 32'h1122AA44});
        vecs.push_back('{"lw_merged", 1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h1122AA44, 1'b0, 2, 0, 32'd0, 32'h0});
        vecs.push_back('{"sw_8000",   1'b1, 2'b10, 1'b0, 32'h10,  32'h8000FF80, 32'h0,        1'b0, 2, 1, 32'd4, 32'h8000FF80});
        vecs.push_back('{"lb_s_10",   1'b0, 2'b00, 1'b1, 32'h10,  32'h0,        32'hFFFFFF80, 1'b0, 2, 0, 32'd0, 32'h0});
        vecs.push_back('{"lh_u_12",   1'b0, 2'b01, 1'b0, 32'h12,  32'h0,        32'h00008000, 1'b0, 2, 0, 32'd0, 32'h0});
        vecs.push_back('{"lh_s_12",   1'b0, 2'b01, 1'b1, 32'h12,  32'h0,        32'hFFFF8000, 1'b0, 2, 0, 32'd0, 32'h0});
        vecs.push_back('{"lb_u_11",   1'b0, 2'b00, 1'b0, 32'h11,  32'h0,        32'h000000FF, 1'b0, 2, 0, 32'd0, 32'h0});
        vecs.push_back('{"lb_s_11",   1'b0, 2'b00, 1'b1, 32'h11,  32'h0,        32'hFFFFFFFF, 1'b0, 2, 0, 32'd0, 32'h0});
        vecs.push_back('{"lb_u_13",   1'b0, 2'b00, 1'b0, 32'h13,  32'h0,        32'h00000080, 1'b0, 2, 0, 32'd0, 32'h0});
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back('{"lw_mis_12", 1'b0, 2'b10, 1'b0, 32'h12,  32'h0,        32'h0,        1'b1, 1, 0, 32'd0, 32'h0});
`else
        vecs.push_back('{"lw_mis_12", 1'b0, 2'b10, 1'b0, 32'h12,  32'h0,        32'h8000FF80, 1'b0, 2, 0, 32'd0, 32'h0});
`endif
        vecs.push_back('{"lw_oor",    1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 1, 0, 32'd0, 32'h0});
        vecs.push_back('{"sw_oor",    1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678, 32'h0,        1'b1, 1, 0, 32'd0, 32'h0});
        vecs.push_back('{"lx_illsz",  1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1, 1, 0, 32'd0, 32'h0});
        vecs.push_back('{"sx_illsz",  1'b1, 2'b11, 1'b0, 32'h10,  32'hCAFEF00D, 32'h0,        1'b1, 1, 0, 32'd0, 32'h0});
        vecs.push_back('{"sh_16",     1'b1, 2'b01, 1'b0, 32'h16,  32'h1234BEEF, 32'h0,        1'b0, 3, 1, 32'd5, 32'hBEEF0000});
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back('{"sh_mis_15", 1'b1, 2'b01, 1'b0, 32'h15,  32'h00005555, 32'h0,        1'b1, 1, 0, 32'd0, 32'h0});
        vecs.push_back('{"lw_14",     1'b0, 2'b10, 1'b0, 32'h14,  32'h0,        32'hBEEF0000, 1'b0, 2, 0, 32'd0, 32'h0});
`else
        vecs.push_back('{"sh_mis_15", 1'b1, 2'b01, 1'b0, 32'h15,  32'h00005555, 32'h0,        1'b0, 3, 1, 32'd5, 32'hBEEF5555});
        vecs.push_back('{"lw_14",     1'b0, 2'b10, 1'b0, 32'h14,  32'h0,        32'hBEEF5555, 1'b0, 2, 0, 32'd0, 32'h0});
`endif
        vecs.push_back('{"sb_top",    1'b1, 2'b00, 1'b0, 32'hFF,  32'h0000005A, 32'h0,        1'b0, 3, 1, 32'd63, 32'h5A000000});
        vecs.push_back('{"lw_top",    1'b0, 2'b10, 1'b0, 32'hFC,  32'h0,        32'h5A000000, 1'b0, 2, 0, 32'd0, 32'h0});

        #1;
        check_reset_vals("rst_init");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn(vecs[i], 0);
        end

        // Backpressure: response held for 5 cycles.
        run_txn('{"lw_hold", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8000FF80, 1'b0, 2, 0, 32'd0, 32'h0}, 5);

        // Reset asserted while a sub-word store is in WRITE.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h20;
        req_wdata = 32'h00000077;
        wr0       = wr_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rstw_in_write", 32'(mem_writeEn), 32'h1);
        reset = 1'b0;
        #1;
        check_reset_vals("rstw");
        @(negedge clk);
        check("rstw_no_write", 32'(wr_cnt - wr0), 32'h0);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rstw_no_resp", 32'(resp_valid), 32'h0);
        end
        run_txn('{"lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 2, 0, 32'd0, 32'h0}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
